// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states and the latched operation.
package mem_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10
   } arb_op_t;

   // Read wins when a client raises both strobes; the write is dropped.
   function automatic arb_op_t decode_op(input logic rd, input logic wr);
      if (rd)
         return OP_READ;
      else if (wr)
         return OP_WRITE;
      else
         return OP_NONE;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_priority_encoder.sv
// Round-robin priority encoder: first requesting index at or after rr_ptr, wrapping.
module rr_priority_encoder #(
   parameter int NUM_PORTS = 2
) (
   input  logic [NUM_PORTS-1:0]         request,
   input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr,
   output logic                         valid,
   output logic [$clog2(NUM_PORTS)-1:0] winner
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   int               idx;
   logic [IDX_W-1:0] sel;

   // Scan from the farthest candidate down to rr_ptr so the nearest hit overwrites.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = 0;
      sel    = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_PORTS)
            idx = idx - NUM_PORTS;
         sel = IDX_W'(idx);
         if (request[sel]) begin
            valid  = 1'b1;
            winner = sel;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// N-port round-robin memory arbiter; latches the winning request for the whole transaction.
//
// state    | meaning
// ARB_IDLE | no transaction; a pending request is granted at the next edge
// ARB_BUSY | latched request driven to memory until mem_resp
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 128,
   parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_PORTS-1:0]             port_read,
   input  logic [NUM_PORTS-1:0]             port_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
   input  logic [NUM_PORTS*MASK_WIDTH-1:0]  port_byte_enable,
   output logic [NUM_PORTS-1:0]             port_resp,
   output logic [DATA_WIDTH-1:0]            port_rdata,
   output logic                             mem_read,
   output logic                             mem_write,
   output logic [ADDR_WIDTH-1:0]            mem_address,
   output logic [DATA_WIDTH-1:0]            mem_wdata,
   output logic [MASK_WIDTH-1:0]            mem_byte_enable,
   input  logic                             mem_resp,
   input  logic [DATA_WIDTH-1:0]            mem_rdata,
   output logic                             busy
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   arb_state_t             state, next_state;
   arb_op_t                op_q;
   logic [IDX_W-1:0]       grant_q, rr_ptr, win_idx;
   logic                   win_valid, take;
   logic [NUM_PORTS-1:0]   request;
   logic [ADDR_WIDTH-1:0]  win_addr, addr_q;
   logic [DATA_WIDTH-1:0]  win_wdata, wdata_q;
   logic [MASK_WIDTH-1:0]  win_be, be_q;

   assign request = port_read | port_write;

   rr_priority_encoder #(.NUM_PORTS(NUM_PORTS)) u_rr_enc (
      .request (request),
      .rr_ptr  (rr_ptr),
      .valid   (win_valid),
      .winner  (win_idx)
   );

   // Select the winner's address, data and mask from the packed client buses.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_be    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_addr  = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            win_be    = port_byte_enable[i*MASK_WIDTH +: MASK_WIDTH];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ARB_IDLE;
      else
         state <= next_state;
   end

   // Next state and handshake outputs; memory strobes only ever come from BUSY.
   always_comb begin
      next_state = state;
      take       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      busy       = 1'b0;
      port_resp  = '0;
      case (state)
         ARB_IDLE: begin
            if (win_valid) begin
               take       = 1'b1;
               next_state = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            busy      = 1'b1;
            mem_read  = (op_q == OP_READ);
            mem_write = (op_q == OP_WRITE);
            if (mem_resp) begin
               port_resp[grant_q] = 1'b1;
               next_state         = ARB_IDLE;
            end
         end
         default: next_state = ARB_IDLE;
      endcase
   end

   // Capture the grant and advance the round-robin pointer past the winner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_q <= '0;
         rr_ptr  <= '0;
         op_q    <= OP_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (take) begin
         grant_q <= win_idx;
         op_q    <= decode_op(port_read[win_idx], port_write[win_idx]);
         addr_q  <= win_addr;
         wdata_q <= win_wdata;
         be_q    <= win_be;
         rr_ptr  <= (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   assign mem_address     = addr_q;
   assign mem_wdata       = wdata_q;
   assign mem_byte_enable = be_q;
   assign port_rdata      = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized clients and memory,
// all compared against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int N  = 2;
   localparam int AW = 16;
   localparam int DW = 128;
   localparam int MW = DW / 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      port_read, port_write, port_resp;
   logic [N*AW-1:0]   port_address;
   logic [N*DW-1:0]   port_wdata;
   logic [N*MW-1:0]   port_byte_enable;
   logic [DW-1:0]     port_rdata, mem_wdata, mem_rdata;
   logic              mem_read, mem_write, mem_resp, busy;
   logic [AW-1:0]     mem_address;
   logic [MW-1:0]     mem_byte_enable;

   mem_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
      .clk              (clk),
      .reset            (reset),
      .port_read        (port_read),
      .port_write       (port_write),
      .port_address     (port_address),
      .port_wdata       (port_wdata),
      .port_byte_enable (port_byte_enable),
      .port_resp        (port_resp),
      .port_rdata       (port_rdata),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_address      (mem_address),
      .mem_wdata        (mem_wdata),
      .mem_byte_enable  (mem_byte_enable),
      .mem_resp         (mem_resp),
      .mem_rdata        (mem_rdata),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Transaction-level model: is a transfer outstanding, for whom, and what was captured.
   bit            m_busy;
   int            m_rr, m_g, m_op;   // m_op: 0 none, 1 read, 2 write
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [MW-1:0] m_be;
   int            lat;
   logic [N-1:0]  last_resp;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy    = 1'b0;
      m_rr      = 0;
      m_g       = 0;
      m_op      = 0;
      m_addr    = '0;
      m_wdata   = '0;
      m_be      = '0;
      lat       = 0;
      last_resp = '0;
   endtask

   task automatic check_outputs();
      logic [N-1:0] exp_resp;
      exp_resp = '0;
      if (m_busy && mem_resp)
         exp_resp[m_g] = 1'b1;
      chk("mem_read",        mem_read,        m_busy && m_op == 1);
      chk("mem_write",       mem_write,       m_busy && m_op == 2);
      chk("mem_address",     mem_address,     m_addr);
      chk("mem_wdata",       mem_wdata,       m_wdata);
      chk("mem_byte_enable", mem_byte_enable, m_be);
      chk("port_resp",       port_resp,       exp_resp);
      chk("port_rdata",      port_rdata,      mem_rdata);
      chk("busy",            busy,            m_busy);
      last_resp = exp_resp;
   endtask

   // Called at posedge+2 with inputs set: check this cycle, advance the model, move to next cycle.
   task automatic cyc();
      int found;
      #1;
      check_outputs();
      if (m_busy) begin
         if (mem_resp)
            m_busy = 1'b0;
      end else begin
         found = -1;
         for (int k = 0; k < N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (found < 0 && (port_read[p] || port_write[p]))
               found = p;
         end
         if (found >= 0) begin
            m_g     = found;
            m_op    = port_read[found] ? 1 : 2;
            m_addr  = port_address[found*AW +: AW];
            m_wdata = port_wdata[found*DW +: DW];
            m_be    = port_byte_enable[found*MW +: MW];
            m_rr    = (found + 1) % N;
            m_busy  = 1'b1;
            lat     = $urandom_range(0, 3);
         end
      end
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      port_read        = '0;
      port_write       = '0;
      port_address     = '0;
      port_wdata       = '0;
      port_byte_enable = '0;
      mem_resp         = 1'b0;
      mem_rdata        = '0;
   endtask

   // Asynchronous reset applied mid-cycle; released at posedge+2 of the following cycle.
   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   localparam logic [DW-1:0] W1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [DW-1:0] DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

   bit   pend [N];
   bit   rdf  [N];
   bit   wrf  [N];
   int   nfair;

   initial begin
      reset = 1'b0;
      clear_inputs();
      model_reset();
      @(posedge clk);
      #2;
      do_reset();

      // Single read: request in cycle 0, mem_resp in cycle 3.
      port_read = 2'b01;
      port_address[AW-1:0] = 16'h1000;
      cyc();
      #1 chk("sr_mem_read_c1", mem_read, 1'b1);
      cyc();
      cyc();
      mem_resp  = 1'b1;
      mem_rdata = DEAD;
      #1;
      chk("sr_port_resp_c3", port_resp, 2'b01);
      chk("sr_port_rdata",   port_rdata, DEAD);
      chk("sr_mem_read_c3",  mem_read, 1'b1);
      cyc();
      mem_resp  = 1'b0;
      port_read = 2'b00;
      #1;
      chk("sr_mem_read_c4", mem_read, 1'b0);
      chk("sr_busy_c4",     busy, 1'b0);
      cyc();

      // Contention from reset: port0 first, port1 starts two cycles after port0's resp.
      do_reset();
      port_read    = 2'b11;
      port_address = {16'h0B00, 16'h0A00};
      cyc();
      cyc();
      mem_resp = 1'b1;
      #1 chk("ct_resp0", port_resp, 2'b01);
      cyc();
      mem_resp  = 1'b0;
      port_read = 2'b10;
      #1 chk("ct_dead_cycle", mem_read, 1'b0);
      cyc();
      #1;
      chk("ct_mem_read1", mem_read, 1'b1);
      chk("ct_addr1",     mem_address, 16'h0B00);
      mem_resp = 1'b1;
      #1 chk("ct_resp1", port_resp, 2'b10);
      cyc();
      mem_resp  = 1'b0;
      port_read = 2'b00;
      cyc();

      // Fairness: both clients request continuously; grants alternate starting at port0.
      nfair     = 0;
      port_read = 2'b11;
      for (int c = 0; c < 200 && nfair < 8; c++) begin
         mem_resp = m_busy;
         #1;
         if (m_busy) begin
            chk("fair_grant", port_resp, (nfair % 2 == 0) ? 2'b01 : 2'b10);
            nfair++;
         end
         if (nfair == 8)
            port_read = 2'b00;
         cyc();
      end
      mem_resp = 1'b0;
      chk("fair_count", nfair, 8);
      cyc();

      // Write on port1; write data changes mid-transaction but the latched copy holds.
      do_reset();
      port_write = 2'b10;
      port_address[AW +: AW]     = 16'h2002;
      port_byte_enable[MW +: MW] = 16'h0003;
      port_wdata[DW +: DW]       = W1;
      cyc();
      port_wdata[DW +: DW] = '0;
      #1;
      chk("wr_mem_write", mem_write, 1'b1);
      chk("wr_mem_read",  mem_read, 1'b0);
      chk("wr_addr",      mem_address, 16'h2002);
      chk("wr_be",        mem_byte_enable, 16'h0003);
      chk("wr_wdata",     mem_wdata, W1);
      cyc();
      mem_resp = 1'b1;
      cyc();
      mem_resp   = 1'b0;
      port_write = 2'b00;
      cyc();

      // Reset in cycle 2 of a read; a late mem_resp afterwards must be ignored.
      port_read = 2'b01;
      port_address[AW-1:0] = 16'h3000;
      cyc();
      cyc();
      do_reset();
      chk("rs_mem_read", mem_read, 1'b0);
      mem_resp = 1'b1;
      #1;
      chk("rs_port_resp", port_resp, 2'b00);
      chk("rs_busy",      busy, 1'b0);
      cyc();
      mem_resp = 1'b0;
      cyc();

      // Illegal read+write on port0: only the read reaches memory.
      port_read  = 2'b01;
      port_write = 2'b01;
      port_address[AW-1:0] = 16'h4000;
      cyc();
      #1;
      chk("il_mem_read",  mem_read, 1'b1);
      chk("il_mem_write", mem_write, 1'b0);
      mem_resp = 1'b1;
      cyc();
      port_read  = 2'b00;
      port_write = 2'b00;
      mem_resp   = 1'b0;
      cyc();

      // Randomized clients and memory latency, including stray mem_resp in idle.
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         rdf[i]  = 1'b0;
         wrf[i]  = 1'b0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (last_resp[i]) begin
               pend[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
               int r;
               r       = $urandom_range(0, 7);
               pend[i] = 1'b1;
               rdf[i]  = (r <= 3);
               wrf[i]  = (r == 0) || (r >= 4);
            end
            port_read[i]  = pend[i] && rdf[i];
            port_write[i] = pend[i] && wrf[i];
         end
         port_address     = $urandom;
         port_wdata       = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
         port_byte_enable = $urandom;
         mem_rdata        = {$urandom, $urandom, $urandom, $urandom};
         if (m_busy) begin
            if (lat == 0) begin
               mem_resp = 1'b1;
            end else begin
               mem_resp = 1'b0;
               lat--;
            end
         end else begin
            mem_resp = ($urandom_range(0, 7) == 0);
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
